// File: rtl/tbird_light_sched.sv
// Thunderbird tail-light sequencer: arbitrates left/right requests and paces the six-lamp sweep.
// Optional hazard sweep on simultaneous requests is compiled in with `define TBIRD_HAZARD_EN.
module tbird_light_sched #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic left,
  input  logic right,
  output logic LC,
  output logic LB,
  output logic LA,
  output logic RA,
  output logic RB,
  output logic RC,
  output logic busy
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, L1, L2, L3, R1, R2, R3, DARK
`ifdef TBIRD_HAZARD_EN
    , H1, H2, H3
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_left_q, last_left_d;
  logic [5:0]      lamps_q;
  logic            busy_q;
  logic            tick;

  // Lamp pattern ordered {LC, LB, LA, RA, RB, RC}
  function automatic logic [5:0] decode(input state_t s);
    logic [5:0] v;
    v = 6'b000000;
    case (s)
      L1:      v = 6'b001000;
      L2:      v = 6'b011000;
      L3:      v = 6'b111000;
      R1:      v = 6'b000100;
      R2:      v = 6'b000110;
      R3:      v = 6'b000111;
`ifdef TBIRD_HAZARD_EN
      H1:      v = 6'b001100;
      H2:      v = 6'b011110;
      H3:      v = 6'b111111;
`endif
      default: v = 6'b000000;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_left_q <= 1'b0;
      lamps_q     <= 6'b000000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_left_q <= last_left_d;
      lamps_q     <= decode(state_d);
      busy_q      <= (state_d != IDLE);
    end
  end

  // Arbitration in IDLE; elsewhere the prescaler paces the sweep to DARK and back to IDLE
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_left_d = last_left_q;
    tick        = (cnt_q == CNT_MAX);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (left && right) begin
`ifdef TBIRD_HAZARD_EN
          state_d = H1;
`else
          if (last_left_q) begin
            state_d     = R1;
            last_left_d = 1'b0;
          end else begin
            state_d     = L1;
            last_left_d = 1'b1;
          end
`endif
        end else if (left) begin
          state_d     = L1;
          last_left_d = 1'b1;
        end else if (right) begin
          state_d     = R1;
          last_left_d = 1'b0;
        end
      end
      default: begin
        if (tick) begin
          cnt_d = '0;
          case (state_q)
            L1:      state_d = L2;
            L2:      state_d = L3;
            L3:      state_d = DARK;
            R1:      state_d = R2;
            R2:      state_d = R3;
            R3:      state_d = DARK;
`ifdef TBIRD_HAZARD_EN
            H1:      state_d = H2;
            H2:      state_d = H3;
            H3:      state_d = DARK;
`endif
            default: state_d = IDLE;
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  assign {LC, LB, LA, RA, RB, RC} = lamps_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_tbird_light_sched.sv
// Scoreboarded bench for tbird_light_sched: a sequence-level reference model predicts lamps/busy
// each cycle; a monitor pops predictions on the falling edge and compares them to the DUT.
module tb_tbird_light_sched;

  localparam int unsigned TD = 4;

  logic clk = 1'b0;
  logic rst, left, right;
  logic LC, LB, LA, RA, RB, RC, busy;

  tbird_light_sched #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .left(left), .right(right),
    .LC(LC), .LB(LB), .LA(LA), .RA(RA), .RB(RB), .RC(RC), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [6:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  // Reference model: a sequence is a kind plus elapsed cycles; it lasts 4*TD cycles
  typedef enum int {K_L, K_R, K_H} kind_t;
  bit    m_active = 0;
  bit    m_last_left = 0;
  kind_t m_kind = K_L;
  int    m_elapsed = 0;

  function automatic logic [6:0] predict(input bit active, input kind_t k, input int elapsed);
    int step, lit;
    logic l1, l2, l3, r1, r2, r3;
    if (!active) return 7'b0;
    step = elapsed / int'(TD);
    lit  = (step < 3) ? step + 1 : 0;
    l1 = (k != K_R) && lit >= 1;  l2 = (k != K_R) && lit >= 2;  l3 = (k != K_R) && lit >= 3;
    r1 = (k != K_L) && lit >= 1;  r2 = (k != K_L) && lit >= 2;  r3 = (k != K_L) && lit >= 3;
    return {l3, l2, l1, r1, r2, r3, 1'b1};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_active = 0; m_last_left = 0; m_elapsed = 0;
    end else if (!m_active) begin
      if (left || right) begin
        if (left && right) begin
`ifdef TBIRD_HAZARD_EN
          m_kind = K_H;
`else
          m_kind = m_last_left ? K_R : K_L;
`endif
        end else m_kind = left ? K_L : K_R;
        if (m_kind == K_L) m_last_left = 1;
        if (m_kind == K_R) m_last_left = 0;
        m_active = 1; m_elapsed = 0;
      end
    end else begin
      m_elapsed++;
      if (m_elapsed == 4 * int'(TD)) m_active = 0;
    end
    exp_q.push_back(predict(m_active, m_kind, m_elapsed));
  end

  // Monitor: every cycle presents a lamp/busy pattern
  always @(negedge clk) begin
    logic [6:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {LC, LB, LA, RA, RB, RC, busy};
      n_total++;
      if (a[6:1] == e[6:1]) n_pass++;
      else $display("FAIL lamps cyc=%0d got LC..RC=%b expected %b", cyc, a[6:1], e[6:1]);
      n_total++;
      if (a[0] == e[0]) n_pass++;
      else $display("FAIL busy cyc=%0d got %b expected %b", cyc, a[0], e[0]);
    end
  end

  task automatic drive(input logic r, input logic l, input logic rt, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r; left = l; right = rt;
    end
  endtask

  initial begin
    rst = 1'b1; left = 1'b1; right = 1'b0;
    // Reset held 2 cycles with left high, then left held across several periods
    drive(1, 1, 0, 2);
    drive(0, 1, 0, 40);
    drive(0, 0, 0, 20);
    // Single-cycle right pulse in IDLE
    drive(0, 0, 1, 1);
    drive(0, 0, 0, 25);
    // Both held: alternation (or hazard sweep)
    drive(0, 1, 1, 75);
    drive(0, 0, 0, 20);
    // Reset mid-L2 with left held
    drive(0, 1, 0, 6);
    drive(1, 1, 0, 1);
    drive(0, 1, 0, 20);
    // Requests changing mid-sequence are ignored
    drive(0, 0, 0, 20);
    drive(0, 0, 1, 3);
    drive(0, 1, 0, 10);
    drive(0, 0, 0, 20);
    // Randomized phase
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 99) < 2);
      left  = ($urandom_range(0, 9) < 3);
      right = ($urandom_range(0, 9) < 3);
    end
    drive(0, 0, 0, 25);
    @(negedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tbird_light_sched.md
# tbird_light_sched

Sequencer and arbiter for the Thunderbird tail-light datapath. It takes the raw `left`/`right` turn requests, arbitrates between them, and paces the six lamps (LC LB LA | RA RB RC) through the three-step sweep. A built-in prescaler sets the pace, so the lamps can be driven directly at board clock rate. It sits between the switch inputs and the lamp pins in `top`.

## Interface
Parameters:
- `TICK_DIV`, 4: clock cycles per animation step. Legal range is ≥1. The prescaler width is max(1, $clog2(TICK_DIV)).

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `left`  in  1  left-turn request, level-sensitive.
- `right`  in  1  right-turn request, level-sensitive.
- `LC`, `LB`, `LA`  out  1 each  left lamps, outermost to innermost.
- `RA`, `RB`, `RC`  out  1 each  right lamps, innermost to outermost.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, L1, L2, L3, R1, R2, R3, DARK. H1, H2 and H3 also exist when the hazard feature is compiled in.
- Outputs are Moore outputs, decoded from the state register only:
  - IDLE and DARK: all lamps 0.
  - L1: LA. L2: LA, LB. L3: LA, LB, LC.
  - R1: RA. R2: RA, RB. R3: RA, RB, RC.
  - H1: LA, RA. H2: LA, LB, RA, RB. H3: all six.
- Prescaler counter `cnt`:
  - Held at 0 in IDLE.
  - Counts 0..TICK_DIV-1 in every other state.
  - When `cnt` reaches TICK_DIV-1, the state advances and `cnt` returns to 0.
- Transitions:
  - L1→L2→L3→DARK, R1→R2→R3→DARK, H1→H2→H3→DARK.
  - DARK→IDLE after TICK_DIV cycles.
- IDLE arbitration, sampled each cycle:
  - Only `left` high → L1.
  - Only `right` high → R1.
  - Neither high → stay in IDLE.
  - Both high → see Configuration.
- Round-robin flag `last_left`:
  - Set when L1 is entered, cleared when R1 is entered.
  - Reset value is 0, so left wins the first tie.
- Requests are sampled only in IDLE. Changes to `left`/`right` outside IDLE are ignored, and a started sequence always runs to DARK→IDLE.
- A single-cycle request pulse seen in IDLE starts a full sequence.
- Reset, including mid-sequence, takes effect at the next edge:
  - state = IDLE, `cnt` = 0, `last_left` = 0.
  - All lamps 0, `busy` = 0.
  - `rst` overrides every other input.

## Timing
- Request-to-lamp latency is 1 cycle. If `left` is high in IDLE at edge k, LA is high after edge k.
- Each lit step and the DARK step last exactly TICK_DIV cycles.
- IDLE lasts at least 1 cycle between sequences.
- With a request held, the repeat period is 4·TICK_DIV+1 cycles (17 at default).
- TICK_DIV=1: each step lasts a single cycle, with a period of 5.
- `busy` rises with the first lit step and falls when IDLE is re-entered.

## Configuration
- Macro `TBIRD_HAZARD_EN` defined:
  - Both requests high in IDLE → H1. The hazard sequence is H1→H2→H3→DARK, with identical per-step timing.
  - `last_left` is unchanged by hazard sequences.
- Macro not defined:
  - H states are not synthesized.
  - A tie is granted round-robin: to `right` if `last_left` = 1, otherwise to `left`. Held ties therefore alternate full L and R sequences.

## Test plan
All scenarios use TICK_DIV=4.
- Reset: `rst`=1 for 2 cycles with `left`=1 → all lamps 0 and `busy`=0 during reset. LA rises on the first edge after `rst` falls.
- `left` held: lamps go LA for 4 cycles, LA/LB for 4, LA/LB/LC for 4, dark for 4, IDLE for 1, then repeat. LA rising edges are 17 cycles apart and R lamps stay 0.
- 1-cycle `right` pulse in IDLE: the full R1-R3 and DARK sequence runs, 16 cycles with `busy`=1. The block then stays in IDLE with lamps 0.
- Both held, macro undefined: sequences alternate L, R, L, and so on, with the first sequence being left.
- Both held, `TBIRD_HAZARD_EN` defined: lamps go LA/RA, then LA/LB/RA/RB, then all six, then dark, each for 4 cycles, repeating every 17 cycles.
- `rst` pulsed for 1 cycle mid-L2 with `left` held: lamps are 0 and `busy`=0 the next cycle, then L1 restarts on the following edge.
